bram_uart_dumper: RTL and testbench

//   Reader-side counterpart to the block-RAM writer. Walks an address range on the

---
 rtl/bram_uart_dumper_if.sv | 25 ++
 rtl/bram_uart_dumper.sv | 118 +++++++++++
 tb/tb_bram_uart_dumper.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/bram_uart_dumper_if.sv
// Bundles the dump-control, BRAM port-B and UART-side signals of the RAM dumper.
// The master side is the host/BRAM environment, and the slave side is the dumper.
interface bram_uart_dumper_if #(
  parameter int ADDRESS_BITWIDTH = 10,
  parameter int DATA_BITWIDTH    = 32
);
  logic                        start;
  logic [ADDRESS_BITWIDTH-1:0] first_address;
  logic [ADDRESS_BITWIDTH-1:0] last_address;
  logic [ADDRESS_BITWIDTH-1:0] b_address;
  logic [DATA_BITWIDTH-1:0]    b_data_out;
  logic                        uart_tx;
  logic                        busy;
  logic                        done;

  modport master (
    output start, first_address, last_address, b_data_out,
    input  b_address, uart_tx, busy, done
  );

  modport slave (
    input  start, first_address, last_address, b_data_out,
    output b_address, uart_tx, busy, done
  );
endinterface

// File: rtl/bram_uart_dumper.sv
// Walks a word-address range on BRAM port B and sends each 32-bit word over UART
// as four little-endian 8N1 frames. The frames for one word follow each other back-to-back.
//
// state  | meaning
// IDLE   | waiting for start; latches address range
// FETCH  | BRAM read latency cycle
// LATCH  | capture read word, arm first frame
// SEND   | shifting out 4 frames of the current word
// FINISH | one-cycle done pulse, drop busy
module bram_uart_dumper #(
  parameter int CLK_FREQ         = 27_000_000,
  parameter int BAUD_RATE        = 115_200,
  parameter int ADDRESS_BITWIDTH = 10,
  parameter int DATA_BITWIDTH    = 32
) (
  input logic               sys_clk,
  input logic               sys_rst_n,
  bram_uart_dumper_if.slave bus
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int BAUD_W       = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0] STOP_BIT = 4'd9;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LATCH  = 3'd2;
  localparam logic [2:0] S_SEND   = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  logic [2:0]                  state;
  logic [ADDRESS_BITWIDTH-1:0] cur;
  logic [ADDRESS_BITWIDTH-1:0] last_q;
  logic [ADDRESS_BITWIDTH-1:0] addr_q;
  logic [ADDRESS_BITWIDTH-1:0] cur_next;
  logic [DATA_BITWIDTH-1:0]    word;
  logic [1:0]                  byte_idx;
  logic [3:0]                  bit_idx;
  logic [BAUD_W-1:0]           baud_cnt;
  logic [7:0]                  cur_byte;
  logic                        tx_q;
  logic                        busy_q;
  logic                        done_q;

  assign cur_next = cur + ADDRESS_BITWIDTH'(1);
  assign cur_byte = word[{byte_idx, 3'b000} +: 8];

  assign bus.b_address = addr_q;
  assign bus.uart_tx   = tx_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

  // bit_idx: 0 = start bit, 1..8 = data bits LSB first, 9 = stop bit
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= S_IDLE;
      cur      <= '0;
      last_q   <= '0;
      addr_q   <= '0;
      word     <= '0;
      byte_idx <= '0;
      bit_idx  <= '0;
      baud_cnt <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            cur    <= bus.first_address;
            last_q <= bus.last_address;
            addr_q <= bus.first_address;
            busy_q <= 1'b1;
            state  <= S_FETCH;
          end
        end
        S_FETCH: state <= S_LATCH;
        S_LATCH: begin
          word     <= bus.b_data_out;
          byte_idx <= '0;
          bit_idx  <= '0;
          baud_cnt <= BAUD_LOAD;
          tx_q     <= 1'b0;
          state    <= S_SEND;
        end
        S_SEND: begin
          if (baud_cnt != '0) begin
            baud_cnt <= baud_cnt - BAUD_W'(1);
          end else if (bit_idx != STOP_BIT) begin
            bit_idx  <= bit_idx + 4'd1;
            baud_cnt <= BAUD_LOAD;
            tx_q     <= (bit_idx == 4'd8) ? 1'b1 : cur_byte[bit_idx[2:0]];
          end else if (byte_idx != 2'd3) begin
            // next byte of the same word starts immediately, no idle gap
            byte_idx <= byte_idx + 2'd1;
            bit_idx  <= '0;
            baud_cnt <= BAUD_LOAD;
            tx_q     <= 1'b0;
          end else if (cur == last_q) begin
            done_q <= 1'b1;
            state  <= S_FINISH;
          end else begin
            cur    <= cur_next;
            addr_q <= cur_next;
            state  <= S_FETCH;
          end
        end
        S_FINISH: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bram_uart_dumper.sv
// Directed bench for bram_uart_dumper: table of dump ranges with hand-computed words,
// plus hand sequences for the start-at-done case and a reset in the middle of a dump.
module tb_bram_uart_dumper;
  localparam int CPB      = 8;
  localparam int WORD_CYC = 2 + 40 * CPB;

  typedef struct packed {
    logic [9:0]       first;
    logic [9:0]       last;
    int               nwords;
    logic [2:0][31:0] words;
    int               naddr;
    logic [2:0][9:0]  addrs;
    int               poke;
  } vec_t;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b1;
  always #5 sys_clk = ~sys_clk;

  bram_uart_dumper_if #(.ADDRESS_BITWIDTH(10), .DATA_BITWIDTH(32)) bus ();

  bram_uart_dumper #(
    .CLK_FREQ(8), .BAUD_RATE(1), .ADDRESS_BITWIDTH(10), .DATA_BITWIDTH(32)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  logic [31:0] mem [0:1023];
  always @(posedge sys_clk) bus.b_data_out <= mem[bus.b_address];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // UART receiver model: samples each bit 3 cycles into its 8-cycle window
  logic [7:0] rx_q [$];
  int         ferr = 0;
  initial begin : rx_mon
    logic [7:0] b;
    forever begin
      @(negedge sys_clk);
      if (bus.uart_tx === 1'b0) begin
        repeat (3) @(negedge sys_clk);
        if (bus.uart_tx !== 1'b0) ferr++;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge sys_clk);
          b[i] = bus.uart_tx;
        end
        repeat (CPB) @(negedge sys_clk);
        if (bus.uart_tx !== 1'b1) ferr++;
        rx_q.push_back(b);
      end
    end
  end

  logic [9:0] addr_q [$];
  logic [9:0] last_seen = '0;
  int         done_cnt  = 0;
  always @(negedge sys_clk) begin
    if (bus.done === 1'b1) done_cnt++;
    if (bus.b_address !== last_seen) begin
      if (sys_rst_n) addr_q.push_back(bus.b_address);
      last_seen = bus.b_address;
    end
  end

  vec_t vecs [5];

  task automatic run_vec(input int id, input vec_t v);
    int k;
    bit seen;
    logic [7:0] eb;
    rx_q.delete();
    addr_q.delete();
    done_cnt = 0;
    ferr     = 0;
    @(negedge sys_clk);
    bus.first_address = v.first;
    bus.last_address  = v.last;
    bus.start         = 1'b1;
    @(negedge sys_clk);
    bus.start = 1'b0;
    k = 0;
    check($sformatf("v%0d busy_after_start", id), {31'd0, bus.busy}, 32'd1);
    @(negedge sys_clk); k = 1;
    check($sformatf("v%0d tx_idle_before_frame", id), {31'd0, bus.uart_tx}, 32'd1);
    @(negedge sys_clk); k = 2;
    check($sformatf("v%0d start_bit_latency", id), {31'd0, bus.uart_tx}, 32'd0);
    seen = 1'b0;
    while (!seen && k < WORD_CYC * v.nwords + 50) begin
      @(negedge sys_clk);
      k++;
      if (k == v.poke) begin
        bus.start         = 1'b1;
        bus.first_address = 10'd9;
      end else if (k == v.poke + 1) begin
        bus.start         = 1'b0;
        bus.first_address = v.first;
      end
      if (bus.done === 1'b1) seen = 1'b1;
    end
    check($sformatf("v%0d done_seen", id), {31'd0, seen}, 32'd1);
    check($sformatf("v%0d done_time", id), k, WORD_CYC * v.nwords);
    check($sformatf("v%0d busy_during_done", id), {31'd0, bus.busy}, 32'd1);
    @(negedge sys_clk);
    check($sformatf("v%0d busy_cleared", id), {31'd0, bus.busy}, 32'd0);
    check($sformatf("v%0d done_single", id), {31'd0, bus.done}, 32'd0);
    repeat (20) @(negedge sys_clk);
    check($sformatf("v%0d byte_count", id), rx_q.size(), 4 * v.nwords);
    for (int j = 0; j < 4 * v.nwords; j++) begin
      eb = v.words[j / 4][8 * (j % 4) +: 8];
      check($sformatf("v%0d byte%0d", id, j),
            (j < rx_q.size()) ? {24'd0, rx_q[j]} : 32'h100, {24'd0, eb});
    end
    check($sformatf("v%0d addr_steps", id), addr_q.size(), v.naddr);
    for (int j = 0; j < v.naddr; j++) begin
      check($sformatf("v%0d addr%0d", id, j),
            (j < addr_q.size()) ? {22'd0, addr_q[j]} : 32'h400, {22'd0, v.addrs[j]});
    end
    check($sformatf("v%0d done_pulses", id), done_cnt, 1);
    check($sformatf("v%0d framing", id), ferr, 0);
  endtask

  initial begin
    int k;
    bit seen;

    vecs[0] = '{first: 10'd0, last: 10'd0, nwords: 1,
                words: {32'h0, 32'h0, 32'hABCD_EF12},
                naddr: 0, addrs: {10'd0, 10'd0, 10'd0}, poke: 0};
    vecs[1] = '{first: 10'd5, last: 10'd7, nwords: 3,
                words: {32'h99AA_BBCC, 32'h5566_7788, 32'h1122_3344},
                naddr: 3, addrs: {10'd7, 10'd6, 10'd5}, poke: 0};
    vecs[2] = '{first: 10'd1023, last: 10'd1, nwords: 3,
                words: {32'h0F1E_2D3C, 32'hABCD_EF12, 32'hDEAD_BEEF},
                naddr: 3, addrs: {10'd1, 10'd0, 10'd1023}, poke: 0};
    vecs[3] = '{first: 10'd2, last: 10'd3, nwords: 2,
                words: {32'h0, 32'h0102_0304, 32'h7654_3210},
                naddr: 2, addrs: {10'd0, 10'd3, 10'd2}, poke: 400};
    vecs[4] = '{first: 10'd6, last: 10'd6, nwords: 1,
                words: {32'h0, 32'h0, 32'h5566_7788},
                naddr: 1, addrs: {10'd0, 10'd0, 10'd6}, poke: 0};

    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0]    = 32'hABCD_EF12;
    mem[1]    = 32'h0F1E_2D3C;
    mem[2]    = 32'h7654_3210;
    mem[3]    = 32'h0102_0304;
    mem[5]    = 32'h1122_3344;
    mem[6]    = 32'h5566_7788;
    mem[7]    = 32'h99AA_BBCC;
    mem[9]    = 32'hFFFF_FFFF;
    mem[1023] = 32'hDEAD_BEEF;

    bus.start         = 1'b0;
    bus.first_address = '0;
    bus.last_address  = '0;

    #2 sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("rst uart_tx", {31'd0, bus.uart_tx}, 32'd1);
    check("rst busy", {31'd0, bus.busy}, 32'd0);
    check("rst done", {31'd0, bus.done}, 32'd0);
    check("rst b_address", {22'd0, bus.b_address}, 32'd0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    for (int i = 0; i < 4; i++) run_vec(i, vecs[i]);

    // start held during the done cycle is dropped, then taken one cycle later
    @(negedge sys_clk);
    bus.first_address = 10'd0;
    bus.last_address  = 10'd0;
    bus.start         = 1'b1;
    @(negedge sys_clk);
    bus.start = 1'b0;
    k = 0;
    seen = 1'b0;
    while (!seen && k < WORD_CYC + 50) begin
      @(negedge sys_clk);
      k++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    check("hb done_seen", {31'd0, seen}, 32'd1);
    check("hb done_time", k, WORD_CYC);
    bus.first_address = 10'd5;
    bus.last_address  = 10'd7;
    bus.start         = 1'b1;
    @(negedge sys_clk);
    check("hb start_at_done_ignored", {31'd0, bus.busy}, 32'd0);
    check("hb addr_unchanged", {22'd0, bus.b_address}, 32'd0);
    @(negedge sys_clk);
    bus.start = 1'b0;
    check("hb start_after_done_busy", {31'd0, bus.busy}, 32'd1);
    check("hb start_after_done_addr", {22'd0, bus.b_address}, 32'd5);

    // reset inside data bit 5 of byte 0x44 (a zero bit)
    repeat (49) @(negedge sys_clk);
    check("rc tx_low_before_reset", {31'd0, bus.uart_tx}, 32'd0);
    sys_rst_n = 1'b0;
    #1;
    check("rc uart_tx", {31'd0, bus.uart_tx}, 32'd1);
    check("rc busy", {31'd0, bus.busy}, 32'd0);
    check("rc done", {31'd0, bus.done}, 32'd0);
    check("rc b_address", {22'd0, bus.b_address}, 32'd0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (100) @(negedge sys_clk);
    run_vec(4, vecs[4]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
